axi_lite_regfile: RTL and testbench

AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

---
 rtl/axi_lite_regfile.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: NUM_REGS registers, per-register read-only
// sourcing from hw_in, byte-strobed writes and a per-register write strobe.
module axi_lite_regfile #(
  parameter int unsigned         ADDR_WIDTH = 32,
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}                     r_state_e;

  // Word index decode; byte-offset bits are dropped.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> OFFS_W) < ADDR_WIDTH'(NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'(addr >> OFFS_W);
  endfunction

  w_state_e                             w_state_q, w_state_d;
  r_state_e                             r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0]                awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]                wdata_q, wdata_d;
  logic [STRB_W-1:0]                    wstrb_q, wstrb_d;
  logic [1:0]                           bresp_q, bresp_d;
  logic                                 bvalid_q, bvalid_d;
  logic                                 awready_q, awready_d;
  logic                                 wready_q, wready_d;
  logic [NUM_REGS-1:0]                  wr_pulse_q, wr_pulse_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;
  logic [DATA_WIDTH-1:0]                rdata_q, rdata_d;
  logic [1:0]                           rresp_q, rresp_d;
  logic                                 rvalid_q, rvalid_d;
  logic                                 arready_q, arready_d;

  logic                                 commit;
  logic [ADDR_WIDTH-1:0]                cm_addr;
  logic [DATA_WIDTH-1:0]                cm_data;
  logic [STRB_W-1:0]                    cm_strb;
  logic [IDX_W-1:0]                     cm_idx;
  logic [IDX_W-1:0]                     rd_idx;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  hw_arr;

  assign hw_arr = hw_in;
  assign cm_idx = addr_index(cm_addr);
  assign rd_idx = addr_index(ARADDR);

  // Write channel FSM: collect AW and W in either order, then hold the response.
  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    cm_addr   = AWADDR;
    cm_data   = WDATA;
    cm_strb   = WSTRB;
    unique case (w_state_q)
      W_IDLE: begin
        if (AWVALID && awready_q && WVALID && wready_q) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
        end else if (AWVALID && awready_q) begin
          awaddr_d  = AWADDR;
          w_state_d = W_GOT_AW;
        end else if (WVALID && wready_q) begin
          wdata_d   = WDATA;
          wstrb_d   = WSTRB;
          w_state_d = W_GOT_W;
        end
      end
      W_GOT_AW: begin
        if (WVALID && wready_q) begin
          commit    = 1'b1;
          cm_addr   = awaddr_q;
          w_state_d = W_RESP;
        end
      end
      W_GOT_W: begin
        if (AWVALID && awready_q) begin
          commit    = 1'b1;
          cm_data   = wdata_q;
          cm_strb   = wstrb_q;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    if (commit) bresp_d = addr_in_range(cm_addr) ? RESP_OKAY : RESP_SLVERR;
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_GOT_W);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_GOT_AW);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Register update and write strobe on commit; RO registers only strobe.
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (commit && addr_in_range(cm_addr)) begin
      wr_pulse_d[cm_idx] = 1'b1;
      if (!RO_MASK[cm_idx]) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (cm_strb[b]) regs_d[cm_idx][b*8 +: 8] = cm_data[b*8 +: 8];
        end
      end
    end
  end

  // Read channel FSM: capture data at the AR handshake, hold until RREADY.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ARVALID && arready_q) begin
          r_state_d = R_DATA;
          if (addr_in_range(ARADDR)) begin
            rresp_d = RESP_OKAY;
            rdata_d = RO_MASK[rd_idx] ? hw_arr[rd_idx] : regs_q[rd_idx];
          end else begin
            rresp_d = RESP_SLVERR;
            rdata_d = '0;
          end
        end
      end
      R_DATA: begin
        if (RREADY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  // State and output registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= '0;
      bvalid_q   <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      wr_pulse_q <= '0;
      regs_q     <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      bvalid_q   <= bvalid_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rvalid_q   <= rvalid_d;
      arready_q  <= arready_d;
    end
  end

  assign AWREADY  = awready_q;
  assign WREADY   = wready_q;
  assign BRESP    = bresp_q;
  assign BVALID   = bvalid_q;
  assign ARREADY  = arready_q;
  assign RDATA    = rdata_q;
  assign RRESP    = rresp_q;
  assign RVALID   = rvalid_q;
  assign reg_out  = regs_q;
  assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Randomized bench for axi_lite_regfile against an array-based register model.
module tb_axi_lite_regfile;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 16;
  localparam logic [NR-1:0] RO = 16'h0088;

  logic             ACLK = 1'b0;
  logic             ARESETn = 1'b0;
  logic [AW-1:0]    AWADDR;
  logic             AWVALID;
  logic             AWREADY;
  logic [DW-1:0]    WDATA;
  logic [DW/8-1:0]  WSTRB;
  logic             WVALID;
  logic             WREADY;
  logic [1:0]       BRESP;
  logic             BVALID;
  logic             BREADY;
  logic [AW-1:0]    ARADDR;
  logic             ARVALID;
  logic             ARREADY;
  logic [DW-1:0]    RDATA;
  logic [1:0]       RRESP;
  logic             RVALID;
  logic             RREADY;
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] hw_in;
  logic [NR-1:0]    wr_pulse;

  axi_lite_regfile #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_out(reg_out), .hw_in(hw_in), .wr_pulse(wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;
  logic [31:0] model  [NR];
  logic [31:0] hw_val [NR];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic apply_hw();
    for (int i = 0; i < NR; i++) hw_in[i*DW +: DW] = hw_val[i];
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
  endtask

  // Only RW registers carry stored state visible on reg_out.
  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++)
      if (!RO[i]) check($sformatf("%s reg%0d", tag, i), 64'(reg_out[i*DW +: DW]), 64'(model[i]));
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [NR-1:0] pulse);
    logic [31:0] idx;
    idx   = addr >> 2;
    pulse = '0;
    if (idx >= NR) begin
      resp = 2'b10;
    end else begin
      resp = 2'b00;
      pulse[idx] = 1'b1;
      if (!RO[idx])
        for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  function automatic logic [33:0] model_read(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    if (idx >= NR) return {2'b10, 32'h0};
    if (RO[idx]) return {2'b00, hw_val[idx]};
    return {2'b00, model[idx]};
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_hold, input string tag);
    bit aw_done, w_done, aw_fire, w_fire;
    int n;
    logic [1:0] eresp;
    logic [NR-1:0] epulse;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge ACLK);
      check({tag, " bvalid_early"}, 64'(BVALID), 64'(0));
      AWADDR  = addr; WDATA = data; WSTRB = strb;
      AWVALID = !aw_done && (n >= aw_dly);
      WVALID  = !w_done && (n >= w_dly);
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      @(posedge ACLK);
      aw_done = aw_done | aw_fire;
      w_done  = w_done | w_fire;
      n++;
    end
    check({tag, " handshake_timeout"}, 64'(aw_done && w_done), 64'(1));
    model_write(addr, data, strb, eresp, epulse);
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    BREADY  = (b_hold == 0);
    check({tag, " bvalid"}, 64'(BVALID), 64'(1));
    check({tag, " bresp"}, 64'(BRESP), 64'(eresp));
    check({tag, " wr_pulse"}, 64'(wr_pulse), 64'(epulse));
    check({tag, " readies_busy"}, 64'({AWREADY, WREADY}), 64'(0));
    check_regs(tag);
    for (int h = 0; h < b_hold; h++) begin
      @(negedge ACLK);
      check({tag, " bvalid_hold"}, 64'({BVALID, BRESP}), 64'({1'b1, eresp}));
      check({tag, " wr_pulse_off"}, 64'(wr_pulse), 64'(0));
      if (h == b_hold - 1) BREADY = 1;
    end
    @(negedge ACLK);
    BREADY = 0;
    check({tag, " bvalid_done"}, 64'(BVALID), 64'(0));
    check({tag, " wr_pulse_done"}, 64'(wr_pulse), 64'(0));
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_hold, input string tag);
    bit done, fire;
    int n;
    logic [33:0] exp;
    done = 0; n = 0;
    while (!done && n < 50) begin
      @(negedge ACLK);
      ARADDR  = addr;
      ARVALID = (n >= ar_dly);
      fire    = ARVALID && ARREADY;
      @(posedge ACLK);
      done = fire;
      n++;
    end
    check({tag, " ar_timeout"}, 64'(done), 64'(1));
    exp = model_read(addr);
    @(negedge ACLK);
    ARVALID = 0;
    RREADY  = (r_hold == 0);
    check({tag, " rvalid"}, 64'(RVALID), 64'(1));
    check({tag, " rdata"}, 64'({RRESP, RDATA}), 64'(exp));
    for (int h = 0; h < r_hold; h++) begin
      @(negedge ACLK);
      check({tag, " rhold"}, 64'({RVALID, ARREADY, RRESP, RDATA}), 64'({2'b10, exp}));
      if (h == r_hold - 1) RREADY = 1;
    end
    @(negedge ACLK);
    RREADY = 0;
    check({tag, " rdone"}, 64'({RVALID, ARREADY}), 64'(2'b01));
  endtask

  initial begin
    logic [1:0] er;
    logic [NR-1:0] ep;
    AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
    ARADDR = 0; ARVALID = 0; RREADY = 0;
    for (int i = 0; i < NR; i++) hw_val[i] = $urandom;
    hw_val[3] = 32'hCAFE0001;
    apply_hw();
    clear_model();

    // Reset state with the clock running.
    repeat (3) @(negedge ACLK);
    check("rst readies", 64'({AWREADY, WREADY, ARREADY}), 64'(0));
    check("rst valids", 64'({BVALID, RVALID}), 64'(0));
    check("rst wr_pulse", 64'(wr_pulse), 64'(0));
    check("rst resp_data", 64'({BRESP, RRESP, RDATA}), 64'(0));
    check("rst reg_out", 64'(reg_out == '0), 64'(1));
    ARESETn = 1;
    #1 check("release readies_low", 64'({AWREADY, WREADY, ARREADY}), 64'(0));
    @(negedge ACLK);
    check("release readies_up", 64'({AWREADY, WREADY, ARREADY}), 64'(3'b111));

    // Directed cases.
    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, "wr_deadbeef");
    check("deadbeef reg1", 64'(reg_out[1*DW +: DW]), 64'(32'hDEADBEEF));
    do_write(32'h08, 32'h11223344, 4'hF, 0, 0, 1, "wr_r2_init");
    do_write(32'h08, 32'h000000AA, 4'h1, 3, 0, 0, "wr_w_then_aw");
    check("strobe reg2", 64'(reg_out[2*DW +: DW]), 64'(32'h112233AA));
    do_write(32'h1B, 32'h55667788, 4'hA, 0, 2, 2, "wr_aw_then_w");
    do_read(32'h40, 0, 0, "rd_oor");
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, 1, 1, 0, "wr_oor");
    do_read(32'h0C, 0, 0, "rd_ro");
    do_write(32'h0C, 32'h0, 4'hF, 0, 0, 0, "wr_ro");
    do_read(32'h0E, 1, 0, "rd_ro_again");
    check("ro value", 64'(RDATA), 64'(32'hCAFE0001));

    // Read backpressure, then concurrent write/read of reg 0.
    do_write(32'h00, 32'h5, 4'hF, 0, 0, 0, "wr_r0_5");
    do_read(32'h00, 0, 5, "rd_backpressure");
    @(negedge ACLK);
    AWADDR = 32'h0; WDATA = 32'h9; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    ARADDR = 32'h0; ARVALID = 1;
    check("conc readies", 64'({AWREADY, WREADY, ARREADY}), 64'(3'b111));
    @(posedge ACLK);
    model_write(32'h0, 32'h9, 4'hF, er, ep);
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1;
    check("conc rdata_old", 64'({RVALID, RDATA}), 64'({1'b1, 32'h5}));
    check("conc bvalid", 64'({BVALID, BRESP}), 64'({1'b1, er}));
    check_regs("conc");
    @(negedge ACLK);
    BREADY = 0; RREADY = 0;
    check("conc done", 64'({BVALID, RVALID}), 64'(0));

    // Random traffic against the model.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $sformatf("rnd_wr%0d", t));
      end else begin
        for (int i = 0; i < NR; i++) if (RO[i]) hw_val[i] = $urandom;
        apply_hw();
        do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd_rd%0d", t));
      end
    end

    // Reset while waiting for W after an AW handshake.
    do_write(32'h10, 32'hA5A5A5A5, 4'hF, 0, 0, 0, "wr_r4");
    @(negedge ACLK);
    AWADDR = 32'h10; AWVALID = 1;
    check("mid aw_ready", 64'(AWREADY), 64'(1));
    @(negedge ACLK);
    AWVALID = 0;
    check("mid got_aw", 64'({AWREADY, WREADY}), 64'(2'b01));
    #2 ARESETn = 0;
    #1;
    check("mid rst readies", 64'({AWREADY, WREADY, ARREADY}), 64'(0));
    check("mid rst valids", 64'({BVALID, RVALID, wr_pulse}), 64'(0));
    check("mid rst resp", 64'({BRESP, RRESP, RDATA}), 64'(0));
    check("mid rst reg_out", 64'(reg_out == '0), 64'(1));
    clear_model();
    @(negedge ACLK);
    ARESETn = 1;
    WDATA = 32'h12345678; WSTRB = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      check("post rst no_resp", 64'({BVALID, wr_pulse}), 64'(0));
    end
    check_regs("post rst");
    do_write(32'h10, 32'h0BADF00D, 4'hF, 0, 0, 0, "wr_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
